// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and types for the reg_file_sb register file.
//   Contents:
//     DEFAULT_DATA_W - default register width in bits
//     DEFAULT_ADDR_W - default address width (depth = 2**ADDR_W)
//     DEFAULT_NREGS  - default depth
//     busy_vec_t     - one busy bit per register at the default depth
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_NREGS  = 1 << DEFAULT_ADDR_W;

  typedef logic [DEFAULT_NREGS-1:0] busy_vec_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Per-register busy bits for in-flight destinations, the issue handshake
//   and a registered count of busy registers.
//   Ports:
//     clk, reset   - clock; asynchronous active-high reset clears all busy bits
//     write        - writeback this cycle, clears busy[writeAdd]
//     writeAdd     - writeback address
//     issue        - request to mark issueAdd busy
//     issueAdd     - destination being issued
//     busy         - full busy vector (stored state)
//     issueReady   - issue is accepted this cycle
//     busyCount    - registered population count of busy
//
//   Handshake: issue/issueReady follow valid/ready rules. A transfer happens
//   on a rising edge where issue and issueReady are both 1. While issueReady
//   is 0 the requester keeps issue and issueAdd stable; issueReady never
//   depends on issue itself.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int ADDR_W = DEFAULT_ADDR_W,
  localparam int NREGS  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAdd,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issueAdd,
  output logic [NREGS-1:0]  busy,
  output logic              issueReady,
  output logic [ADDR_W:0]   busyCount
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic [ADDR_W:0]  r_count;
  logic [ADDR_W:0]  w_count_next;
  logic             w_wb_hit;

  // A pending destination may be re-issued only when its writeback lands on
  // the same edge; otherwise the issue would be a WAW on a live result.
  always_comb begin
    w_wb_hit   = write && (writeAdd == issueAdd);
    issueReady = ~reset & ~(r_busy[issueAdd] & ~w_wb_hit);
  end

  // Clear first, then set: an accepted issue to the address being written
  // back leaves the register busy.
  always_comb begin
    w_busy_next = r_busy;
    if (write) begin
      w_busy_next[writeAdd] = 1'b0;
    end
    if (issue && issueReady) begin
      w_busy_next[issueAdd] = 1'b1;
    end
  end

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_count_next = w_count_next + {{ADDR_W{1'b0}}, w_busy_next[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= w_count_next;
    end
  end

  assign busy      = r_busy;
  assign busyCount = r_count;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Parametrised register file with two combinational read ports, one
//   synchronous write port and a busy scoreboard for hazard detection.
//   Ports:
//     clk, reset           - clock; asynchronous active-high reset clears
//                            all registers and busy bits
//     readAdd1/2           - read addresses
//     out1/2               - read data
//     busy1/2              - busy bit of the addressed register
//     write, writeAdd, in  - writeback port (clears busy[writeAdd])
//     issue, issueAdd      - issue request (marks issueAdd busy)
//     issueReady           - issue accepted this cycle
//     busyCount            - number of busy registers
//   Build option:
//     REGFILE_BYPASS_EN    - when defined, a read of the address being
//                            written shows the write data and busy = 0 in the
//                            same cycle; otherwise reads show stored state.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int ADDR_W = DEFAULT_ADDR_W,
  localparam int NREGS  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readAdd1,
  input  logic [ADDR_W-1:0] readAdd2,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              busy1,
  output logic              busy2,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAdd,
  input  logic [DATA_W-1:0] in,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issueAdd,
  output logic              issueReady,
  output logic [ADDR_W:0]   busyCount
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [NREGS-1:0]  w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (write) begin
      r_mem[writeAdd] <= in;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .writeAdd   (writeAdd),
    .issue      (issue),
    .issueAdd   (issueAdd),
    .busy       (w_busy),
    .issueReady (issueReady),
    .busyCount  (busyCount)
  );

  always_comb begin
    out1  = r_mem[readAdd1];
    out2  = r_mem[readAdd2];
    busy1 = w_busy[readAdd1];
    busy2 = w_busy[readAdd2];
`ifdef REGFILE_BYPASS_EN
    // Forward the writeback; the reader sees the value that is about to
    // land, so the register is already not busy from its point of view.
    if (!reset && write && (writeAdd == readAdd1)) begin
      out1  = in;
      busy1 = 1'b0;
    end
    if (!reset && write && (writeAdd == readAdd2)) begin
      out2  = in;
      busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- default instance ----------------
  logic [2:0]  readAdd1, readAdd2, writeAdd, issueAdd;
  logic [15:0] out1, out2, din;
  logic        busy1, busy2, write, issue, issueReady;
  logic [3:0]  busyCount;

  reg_file_sb dut (
    .clk(clk), .reset(reset),
    .readAdd1(readAdd1), .readAdd2(readAdd2),
    .out1(out1), .out2(out2), .busy1(busy1), .busy2(busy2),
    .write(write), .writeAdd(writeAdd), .in(din),
    .issue(issue), .issueAdd(issueAdd), .issueReady(issueReady),
    .busyCount(busyCount)
  );

  // ---------------- wide instance (32 x 16) ----------------
  logic [3:0]  w_ra1, w_ra2, w_wa, w_ia;
  logic [31:0] w_out1, w_out2, w_din;
  logic        w_b1, w_b2, w_wr, w_iss, w_rdy;
  logic [4:0]  w_cnt;

  reg_file_sb #(.DATA_W(32), .ADDR_W(4)) dut32 (
    .clk(clk), .reset(reset),
    .readAdd1(w_ra1), .readAdd2(w_ra2),
    .out1(w_out1), .out2(w_out2), .busy1(w_b1), .busy2(w_b2),
    .write(w_wr), .writeAdd(w_wa), .in(w_din),
    .issue(w_iss), .issueAdd(w_ia), .issueReady(w_rdy),
    .busyCount(w_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_mem [8];
  busy_vec_t   m_busy;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic logic m_ready();
    if (m_busy[issueAdd] && !(write && writeAdd == issueAdd)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_out(input logic [2:0] a);
    if (BYP && write && writeAdd == a) return din;
    return m_mem[a];
  endfunction

  function automatic logic m_busy_rd(input logic [2:0] a);
    if (BYP && write && writeAdd == a) return 1'b0;
    return m_busy[a];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wr, input logic [2:0] wa, input logic [15:0] d,
                       input logic iss, input logic [2:0] ia,
                       input logic [2:0] ra1, input logic [2:0] ra2);
    @(negedge clk);
    write = wr; writeAdd = wa; din = d;
    issue = iss; issueAdd = ia;
    readAdd1 = ra1; readAdd2 = ra2;
    #1;
  endtask

  task automatic commit();
    logic acc;
    acc = issue && m_ready();
    @(posedge clk);
    if (write) begin
      m_mem[writeAdd]  = din;
      m_busy[writeAdd] = 1'b0;
    end
    if (acc) m_busy[issueAdd] = 1'b1;
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out1"},  out1,       m_out(readAdd1));
    chk({tag, ".out2"},  out2,       m_out(readAdd2));
    chk({tag, ".busy1"}, busy1,      m_busy_rd(readAdd1));
    chk({tag, ".busy2"}, busy2,      m_busy_rd(readAdd2));
    chk({tag, ".rdy"},   issueReady, m_ready());
    chk({tag, ".cnt"},   busyCount,  m_count());
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    write = 0; issue = 0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wr;
    logic [2:0]  wa;
    logic [15:0] d;
    logic        iss;
    logic [2:0]  ia;
    logic [2:0]  ra1, ra2;
    logic [15:0] e_out1, e_out2;
    logic        e_b1, e_b2, e_rdy;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [15:0] old3;

    // wr wa d        iss ia ra1 ra2  out1     out2     b1 b2 rdy cnt
    vecs[0] = '{0, 0, 16'h0000, 0, 0, 0, 7, 16'h0000, 16'h0000, 0, 0, 1, 0};
    vecs[1] = '{1, 3, 16'hBEEF, 0, 0, 1, 2, 16'h0000, 16'h0000, 0, 0, 1, 0};
    vecs[2] = '{0, 0, 16'h0000, 0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0, 0, 1, 0};
    vecs[3] = '{0, 0, 16'h0000, 1, 5, 5, 3, 16'h0000, 16'hBEEF, 0, 0, 1, 0};
    vecs[4] = '{0, 0, 16'h0000, 1, 5, 5, 5, 16'h0000, 16'h0000, 1, 1, 0, 1};
    vecs[5] = '{1, 5, 16'h1234, 0, 5, 3, 4, 16'hBEEF, 16'h0000, 0, 0, 1, 1};
    vecs[6] = '{0, 0, 16'h0000, 0, 0, 5, 5, 16'h1234, 16'h1234, 0, 0, 1, 0};
    vecs[7] = '{0, 0, 16'h0000, 1, 2, 2, 0, 16'h0000, 16'h0000, 0, 0, 1, 0};
    vecs[8] = '{1, 2, 16'hA5A5, 1, 2, 0, 1, 16'h0000, 16'h0000, 0, 0, 1, 1};
    vecs[9] = '{0, 0, 16'h0000, 0, 2, 2, 2, 16'hA5A5, 16'hA5A5, 1, 1, 0, 1};

    reset = 1'b1;
    write = 0; writeAdd = 0; din = 0; issue = 0; issueAdd = 0;
    readAdd1 = 0; readAdd2 = 0;
    w_wr = 0; w_wa = 0; w_din = 0; w_iss = 0; w_ia = 0; w_ra1 = 0; w_ra2 = 0;
    model_clear();

    // During reset: nothing busy, issue refused.
    #2;
    chk("rst.rdy", issueReady, 1'b0);
    chk("rst.cnt", busyCount, 4'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Post-reset read sweep.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
      chk("sweep.out1", out1, 16'h0);
      chk("sweep.out2", out2, 16'h0);
      chk("sweep.busy", {busy1, busy2}, 2'b00);
      chk("sweep.rdy", issueReady, 1'b1);
      chk("sweep.cnt", busyCount, 4'd0);
      commit();
    end

    // Directed table.
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].wr, vecs[v].wa, vecs[v].d, vecs[v].iss, vecs[v].ia,
            vecs[v].ra1, vecs[v].ra2);
      chk($sformatf("vec%0d.out1", v),  out1,       vecs[v].e_out1);
      chk($sformatf("vec%0d.out2", v),  out2,       vecs[v].e_out2);
      chk($sformatf("vec%0d.busy1", v), busy1,      vecs[v].e_b1);
      chk($sformatf("vec%0d.busy2", v), busy2,      vecs[v].e_b2);
      chk($sformatf("vec%0d.rdy", v),   issueReady, vecs[v].e_rdy);
      chk($sformatf("vec%0d.cnt", v),   busyCount,  vecs[v].e_cnt);
      commit();
    end

    // Same-cycle forwarding view: write R3 and issue R3 while reading it.
    old3 = m_mem[3];
    drive(1, 3, 16'hC0DE, 1, 3, 3, 3);
    chk("byp.out1", out1, BYP ? 16'hC0DE : old3);
    chk("byp.busy1", busy1, 1'b0);
    check_model("byp");
    commit();
    drive(0, 0, 0, 0, 0, 3, 3);
    chk("byp.after.out1", out1, 16'hC0DE);
    chk("byp.after.busy1", busy1, 1'b1);
    check_model("byp.after");
    commit();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      check_model("rand");
      commit();
    end

    // Write and issue every register (issue wins), then async reset mid-cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i), 16'(i * 16'h1111 + 1), 1, 3'(i), 3'(i), 3'(i));
      chk("fill.rdy", issueReady, 1'b1);
      commit();
    end
    drive(0, 0, 0, 0, 0, 3, 6);
    chk("fill.cnt", busyCount, 4'd8);
    chk("fill.out1", out1, 16'h3334);
    chk("fill.out2", out2, 16'h6667);
    chk("fill.busy", {busy1, busy2}, 2'b11);
    #1;
    reset = 1'b1;
    #1;
    chk("arst.cnt", busyCount, 4'd0);
    chk("arst.out1", out1, 16'h0);
    chk("arst.out2", out2, 16'h0);
    chk("arst.busy", {busy1, busy2}, 2'b00);
    chk("arst.rdy", issueReady, 1'b0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 3, 6);
    check_model("arst.after");
    commit();

    // Wide instance: top register only.
    @(negedge clk);
    w_wr = 1; w_wa = 4'd15; w_din = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    w_wr = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      w_ra1 = 4'(i);
      w_ra2 = 4'(15 - i);
      #1;
      chk($sformatf("w32.r%0d", i), w_out1, (i == 15) ? 32'hFFFF_FFFF : 32'h0);
      chk($sformatf("w32.r%0d.p2", 15 - i), w_out2, (i == 0) ? 32'hFFFF_FFFF : 32'h0);
    end
    chk("w32.cnt", w_cnt, 5'd0);
    chk("w32.rdy", w_rdy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
